// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation encodings shared by the execute stage and ALU decoder
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASS = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 4'b1100;

  // Branch offsets are in instruction words; this converts them to bytes.
  localparam int BRANCH_SHIFT = 2;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: operation select and zero detect
module alu
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0]          a,
  input  logic [N-1:0]          b,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  output logic [N-1:0]          result,
  output logic                  zero
);

  // Undefined codes yield 0, which deliberately reports zero=1.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_PASS: result = b;
      ALU_NOR:  result = ~(a | b);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - pipeline execute stage: operand mux, ALU, branch target, output register
module execute_stage
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  AluSrc,
  input  logic [ALU_CTRL_W-1:0] AluControl,
  input  logic [N-1:0]          PC_E,
  input  logic [N-1:0]          signImm_E,
  input  logic [N-1:0]          readData1_E,
  input  logic [N-1:0]          readData2_E,
  output logic [N-1:0]          PCBranch_E,
  output logic [N-1:0]          aluResult_E,
  output logic [N-1:0]          writeData_E,
  output logic                  zero_E
);

  logic [N-1:0] src_b;
  logic [N-1:0] branch_target;
  logic [N-1:0] alu_result;
  logic         alu_zero;

  assign src_b         = AluSrc ? signImm_E : readData2_E;
  assign branch_target = PC_E + (signImm_E << BRANCH_SHIFT);

  alu #(.N(N)) u_alu (
    .a           (readData1_E),
    .b           (src_b),
    .alu_control (AluControl),
    .result      (alu_result),
    .zero        (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      PCBranch_E  <= '0;
      aluResult_E <= '0;
      writeData_E <= '0;
      zero_E      <= 1'b0;
    end else begin
      PCBranch_E  <= branch_target;
      aluResult_E <= alu_result;
      writeData_E <= readData2_E;
      zero_E      <= alu_zero;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;

  typedef struct {
    logic        src;
    logic [3:0]  op;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        AluSrc;
  logic [3:0]  AluControl;
  logic [63:0] PC_E, signImm_E, readData1_E, readData2_E;
  logic [63:0] PCBranch_E, aluResult_E, writeData_E;
  logic        zero_E;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_pb, exp_ar, exp_wd;
  logic        exp_z;
  bit          have_exp = 0;

  execute_stage #(.N(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .PCBranch_E  (PCBranch_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
    .zero_E      (zero_E)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return b;
      4'd12:   return ~(a | b);
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: capture what each edge must produce from the inputs present at that edge.
  always @(posedge clk) begin
    logic [63:0] bop;
    bop = AluSrc ? signImm_E : readData2_E;
    if (reset !== 1'b1) begin
      exp_pb = 0; exp_ar = 0; exp_wd = 0; exp_z = 0;
    end else begin
      exp_ar = model_alu(AluControl, readData1_E, bop);
      exp_pb = PC_E + signImm_E * 64'd4;
      exp_wd = readData2_E;
      exp_z  = (exp_ar == 64'd0);
    end
    have_exp = 1;
  end

  always @(negedge clk) begin
    if (have_exp) begin
      chk("model_pcbranch", PCBranch_E, exp_pb);
      chk("model_aluresult", aluResult_E, exp_ar);
      chk("model_writedata", writeData_E, exp_wd);
      chk("model_zero", {63'd0, zero_E}, {63'd0, exp_z});
    end
  end

  task automatic drive(input vec_t v, input logic rst);
    reset       = rst;
    AluSrc      = v.src;
    AluControl  = v.op;
    PC_E        = v.pc;
    signImm_E   = v.imm;
    readData1_E = v.a;
    readData2_E = v.b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [63:0] pb, input logic [63:0] ar,
                     input logic [63:0] wd, input logic z);
    chk({name, "_pcbranch"}, PCBranch_E, pb);
    chk({name, "_aluresult"}, aluResult_E, ar);
    chk({name, "_writedata"}, writeData_E, wd);
    chk({name, "_zero"}, {63'd0, zero_E}, {63'd0, z});
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    v.src = 1'($urandom_range(0, 1));
    v.op  = 4'($urandom_range(0, 15));
    v.pc  = {$urandom, $urandom};
    v.imm = {$urandom, $urandom};
    v.a   = {$urandom, $urandom};
    v.b   = {$urandom, $urandom};
    return v;
  endfunction

  initial begin
    vec_t v, va, vb, vc;

    drive(rnd_vec(), 1'b0);
    step();
    drive(rnd_vec(), 1'b0);
    step();
    lit("reset", 64'd0, 64'd0, 64'd0, 1'b0);

    v = '{1'b0, 4'b0010, 64'd0, 64'd1, 64'd2, 64'd0};
    drive(v, 1'b1); step();
    lit("add_reg", 64'd4, 64'd2, 64'd0, 1'b0);

    v = '{1'b1, 4'b0010, 64'h100, 64'd8, 64'h10, 64'h55};
    drive(v, 1'b1); step();
    lit("add_imm", 64'h120, 64'h18, 64'h55, 1'b0);

    v = '{1'b0, 4'b0110, 64'd0, 64'd0, 64'd5, 64'd5};
    drive(v, 1'b1); step();
    lit("sub_eq", 64'd0, 64'd0, 64'd5, 1'b1);

    v = '{1'b0, 4'b0111, 64'd0, 64'd0, 64'd5, ONES};
    drive(v, 1'b1); step();
    lit("pass_b", 64'd0, ONES, ONES, 1'b0);

    v = '{1'b0, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, ONES, 64'd1};
    drive(v, 1'b1); step();
    lit("wrap", 64'd0, 64'd0, 64'd1, 1'b1);

    v = '{1'b0, 4'b0000, 64'd0, 64'd0, 64'hF0F0, 64'h0FF0};
    drive(v, 1'b1); step();
    lit("and", 64'd0, 64'h00F0, 64'h0FF0, 1'b0);

    v = '{1'b0, 4'b0001, 64'd0, 64'd0, 64'hF000, 64'h000F};
    drive(v, 1'b1); step();
    lit("or", 64'd0, 64'hF00F, 64'h000F, 1'b0);

    v = '{1'b0, 4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_0000};
    drive(v, 1'b1); step();
    lit("nor", 64'd0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_FFFF_0000, 1'b0);

    v = '{1'b0, 4'b0011, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'd9};
    drive(v, 1'b1); step();
    lit("undef", 64'd4, 64'd0, 64'd9, 1'b1);

    v = '{1'b1, 4'b0111, 64'd0, 64'h1234, 64'd0, 64'hABCD};
    drive(v, 1'b1); step();
    lit("pass_imm", 64'h48D0, 64'h1234, 64'hABCD, 1'b0);

    va = '{1'b0, 4'b0010, 64'h10, 64'd2, 64'd3, 64'd4};
    vb = '{1'b0, 4'b0010, 64'h20, 64'd1, 64'd1, 64'd1};
    vc = '{1'b1, 4'b0110, 64'h30, 64'd3, 64'd10, 64'd6};
    drive(va, 1'b1); step();
    lit("b2b_a", 64'h18, 64'd7, 64'd4, 1'b0);
    drive(vb, 1'b0); step();
    lit("b2b_rst", 64'd0, 64'd0, 64'd0, 1'b0);
    drive(vc, 1'b1); step();
    lit("b2b_c", 64'h3C, 64'd7, 64'd6, 1'b0);

    for (int i = 0; i < 40; i++) begin
      drive(rnd_vec(), ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1);
      step();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
